// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset PC, NOP word, FSM states, IF->ID bus width.
package cpu_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
  localparam int          IF_TO_ID_W   = 64;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_inst_buf.sv
// One-entry {pc, inst} holding register between instruction SRAM and decode.
// Load wins over clear; contents persist after clear, only the valid bit drops.
module if_inst_buf
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic                  clear,
  input  logic [IF_TO_ID_W-1:0] load_dat,
  output logic                  valid,
  output logic [IF_TO_ID_W-1:0] dat
);

  logic                  valid_q, valid_d;
  logic [IF_TO_ID_W-1:0] dat_q, dat_d;

  always_comb begin
    valid_d = valid_q;
    dat_d   = dat_q;
    if (load) begin
      valid_d = 1'b1;
      dat_d   = load_dat;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      dat_q   <= {RESET_PC, NOP_INST};
    end else begin
      valid_q <= valid_d;
      dat_q   <= dat_d;
    end
  end

  assign valid = valid_q;
  assign dat   = dat_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding SRAM fetch FSM, redirect, IF->ID hand-off.
// Define IF_ADDR_EXC_EN to trap misaligned PCs locally and raise if_adel.
module if_fetch_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_allowin,
`ifdef IF_ADDR_EXC_EN
  output logic        if_adel,
`endif
  output logic        if_to_id_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         discard_q, discard_d;
  logic         run_q;
  logic         adel_q, adel_d;
  logic         misaligned;

  logic                  buf_load, buf_clear, buf_valid;
  logic [IF_TO_ID_W-1:0] buf_load_dat, buf_dat;

`ifdef IF_ADDR_EXC_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    adel_d        = adel_q;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    buf_load_dat  = {pc_q, inst_sram_rdata};
    inst_sram_req = 1'b0;

    // A redirect always owns the next pc, whatever the state does with the word.
    if (br_taken) begin
      pc_d = br_target;
    end

    case (state_q)
      S_REQ: begin
        if (run_q && misaligned && !br_taken) begin
          buf_load     = 1'b1;
          buf_load_dat = {pc_q, NOP_INST};
          adel_d       = 1'b1;
          state_d      = S_HOLD;
        end else if (run_q && !misaligned) begin
          inst_sram_req = 1'b1;
          if (inst_sram_addr_ok) begin
            state_d   = S_WAIT;
            discard_d = br_taken;
          end
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (discard_q || br_taken) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            buf_load = 1'b1;
            state_d  = S_HOLD;
          end
        end else if (br_taken) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (br_taken || id_allowin) begin
          if (!br_taken) begin
            pc_d = pc_q + 32'd4;
          end
          buf_clear = 1'b1;
          adel_d    = 1'b0;
          state_d   = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      adel_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      adel_q    <= adel_d;
      run_q     <= 1'b1;
    end
  end

  if_inst_buf #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) u_inst_buf (
    .clk      (clk),
    .resetn   (resetn),
    .load     (buf_load),
    .clear    (buf_clear),
    .load_dat (buf_load_dat),
    .valid    (buf_valid),
    .dat      (buf_dat)
  );

  assign inst_sram_addr = pc_q;
  // A redirect kills the held word in the same cycle it is offered.
  assign if_to_id_valid = buf_valid && !br_taken;
  assign if_pc          = buf_dat[63:32];
  assign if_inst        = if_to_id_valid ? buf_dat[31:0] : NOP_INST;

`ifdef IF_ADDR_EXC_EN
  assign if_adel = adel_q && if_to_id_valid;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random SRAM/decode traffic vs a PC-stream model.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef IF_ADDR_EXC_EN
  logic        if_adel;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .id_allowin        (id_allowin),
`ifdef IF_ADDR_EXC_EN
    .if_adel           (if_adel),
`endif
    .if_to_id_valid    (if_to_id_valid),
    .if_pc             (if_pc),
    .if_inst           (if_inst)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    br_taken          = 1'b0;
    br_target         = 32'h0;
    id_allowin        = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", inst_sram_req); end
    n_cmp++; if (if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", if_to_id_valid); end
    n_cmp++; if (if_pc !== RST_PC) begin n_fail++; $display("FAIL rst_pc got=%h exp=%h", if_pc, RST_PC); end
    n_cmp++; if (if_inst !== NOP) begin n_fail++; $display("FAIL rst_inst got=%h exp=%h", if_inst, NOP); end
    resetn = 1'b1;
  endtask

  task automatic test_first_fetch();
    step();
    inst_sram_addr_ok = 1'b1;
    #1;
    n_cmp++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC) begin n_fail++; $display("FAIL ff_req got=%b/%h exp=1/%h", inst_sram_req, inst_sram_addr, RST_PC); end
    step();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h2408_0001;
    #1;
    n_cmp++; if (inst_sram_req !== 1'b0 || if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL ff_wait got req=%b valid=%b exp=0/0", inst_sram_req, if_to_id_valid); end
    step();
    inst_sram_data_ok = 1'b0;
    #1;
    n_cmp++; if (if_to_id_valid !== 1'b1 || if_pc !== RST_PC || if_inst !== 32'h2408_0001) begin n_fail++; $display("FAIL ff_out got=%b/%h/%h exp=1/%h/24080001", if_to_id_valid, if_pc, if_inst, RST_PC); end
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (if_to_id_valid !== 1'b1 || if_pc !== RST_PC || if_inst !== 32'h2408_0001 || inst_sram_req !== 1'b0) begin
        n_fail++; $display("FAIL stall_%0d got=%b/%h/%h req=%b", i, if_to_id_valid, if_pc, if_inst, inst_sram_req);
      end
    end
    id_allowin = 1'b1;
    step();
    id_allowin = 1'b0;
    #1;
    n_cmp++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hBFC0_0004) begin n_fail++; $display("FAIL stall_next got=%b/%h exp=1/bfc00004", inst_sram_req, inst_sram_addr); end
    n_cmp++; if (if_to_id_valid !== 1'b0 || if_inst !== NOP) begin n_fail++; $display("FAIL stall_nop got=%b/%h exp=0/%h", if_to_id_valid, if_inst, NOP); end
  endtask

  task automatic test_redirect_wait();
    inst_sram_addr_ok = 1'b1;
    step();
    inst_sram_addr_ok = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h8000_0100;
    step();
    br_taken = 1'b0;
    step();
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL rw_drop got=%b exp=0", if_to_id_valid); end
    step();
    inst_sram_data_ok = 1'b0;
    #1;
    n_cmp++; if (if_to_id_valid !== 1'b0 || inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL rw_next got=%b/%b/%h exp=0/1/80000100", if_to_id_valid, inst_sram_req, inst_sram_addr); end
  endtask

  task automatic test_redirect_req_accept();
    inst_sram_addr_ok = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h8000_0200;
    step();
    inst_sram_addr_ok = 1'b0;
    br_taken = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h1111_1111;
    step();
    inst_sram_data_ok = 1'b0;
    #1;
    n_cmp++; if (if_to_id_valid !== 1'b0 || inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h8000_0200) begin n_fail++; $display("FAIL ra_next got=%b/%b/%h exp=0/1/80000200", if_to_id_valid, inst_sram_req, inst_sram_addr); end
    inst_sram_addr_ok = 1'b1;
    step();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h2222_2222;
    step();
    inst_sram_data_ok = 1'b0;
    #1;
    n_cmp++; if (if_to_id_valid !== 1'b1 || if_pc !== 32'h8000_0200 || if_inst !== 32'h2222_2222) begin n_fail++; $display("FAIL ra_word got=%b/%h/%h exp=1/80000200/22222222", if_to_id_valid, if_pc, if_inst); end
  endtask

  task automatic test_redirect_hold();
    id_allowin = 1'b1;
    br_taken   = 1'b1;
    br_target  = 32'h8000_0300;
    #1;
    n_cmp++; if (if_to_id_valid !== 1'b0 || if_inst !== NOP) begin n_fail++; $display("FAIL rh_kill got=%b/%h exp=0/%h", if_to_id_valid, if_inst, NOP); end
    step();
    id_allowin = 1'b0;
    br_taken   = 1'b0;
    #1;
    n_cmp++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h8000_0300) begin n_fail++; $display("FAIL rh_next got=%b/%h exp=1/80000300", inst_sram_req, inst_sram_addr); end
  endtask

  task automatic test_mid_reset();
    inst_sram_addr_ok = 1'b1;
    step();
    inst_sram_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    n_cmp++; if (inst_sram_req !== 1'b0 || if_to_id_valid !== 1'b0 || if_pc !== RST_PC) begin n_fail++; $display("FAIL mr got=%b/%b/%h exp=0/0/%h", inst_sram_req, if_to_id_valid, if_pc, RST_PC); end
    step();
    resetn = 1'b1;
  endtask

`ifdef IF_ADDR_EXC_EN
  task automatic test_adel();
    step();
    br_taken  = 1'b1;
    br_target = 32'h8000_0102;
    step();
    br_taken = 1'b0;
    #1;
    n_cmp++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL adel_req got=%b exp=0", inst_sram_req); end
    step();
    n_cmp++; if (if_to_id_valid !== 1'b1 || if_adel !== 1'b1 || if_inst !== NOP || if_pc !== 32'h8000_0102) begin n_fail++; $display("FAIL adel_out got=%b/%b/%h/%h exp=1/1/0/80000102", if_to_id_valid, if_adel, if_inst, if_pc); end
    br_taken  = 1'b1;
    br_target = RST_PC;
    step();
    br_taken = 1'b0;
  endtask
`endif

  // Model: the PC stream decode must see is RESET_PC, +4 per accepted word,
  // replaced by the target on any redirect; each word must be mem_word(pc).
  task automatic test_random();
    logic [31:0] exp_pc = RST_PC;
    logic        outst = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          delay = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc = 32'h0, prev_inst = 32'h0;
    int          delivered = 0;
    logic [31:0] tgt;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      tgt = $urandom;
      br_taken          = ($urandom_range(0, 11) == 0);
      br_target         = tgt & 32'hFFFF_FFFC;
      id_allowin        = ($urandom_range(0, 2) != 0);
      inst_sram_addr_ok = inst_sram_req && ($urandom_range(0, 1) == 1);
      inst_sram_data_ok = outst && (delay == 0);
      inst_sram_rdata   = inst_sram_data_ok ? mem_word(pend_addr) : $urandom;
      #1;
      if (inst_sram_req) begin
        n_cmp++; if (outst) begin n_fail++; $display("FAIL rnd_outstanding cyc=%0d got req=1 exp=0", cyc); end
        if (!br_taken) begin
          n_cmp++; if (inst_sram_addr !== exp_pc) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, inst_sram_addr, exp_pc); end
        end
      end
      if (br_taken) begin
        n_cmp++; if (if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_br_valid cyc=%0d got=%b exp=0", cyc, if_to_id_valid); end
      end
      if (prev_stall && !br_taken) begin
        n_cmp++; if (if_to_id_valid !== 1'b1 || if_pc !== prev_pc || if_inst !== prev_inst) begin n_fail++; $display("FAIL rnd_stable cyc=%0d got=%b/%h/%h exp=1/%h/%h", cyc, if_to_id_valid, if_pc, if_inst, prev_pc, prev_inst); end
      end
      if (if_to_id_valid === 1'b1) begin
        n_cmp++; if (if_pc !== exp_pc || if_inst !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_word cyc=%0d got=%h/%h exp=%h/%h", cyc, if_pc, if_inst, exp_pc, mem_word(exp_pc)); end
      end else begin
        n_cmp++; if (if_inst !== NOP) begin n_fail++; $display("FAIL rnd_nop cyc=%0d got=%h exp=%h", cyc, if_inst, NOP); end
      end
      prev_stall = if_to_id_valid && !id_allowin && !br_taken;
      prev_pc    = if_pc;
      prev_inst  = if_inst;
      if (if_to_id_valid && id_allowin) delivered++;
      if (br_taken) exp_pc = br_target;
      else if (if_to_id_valid && id_allowin) exp_pc = exp_pc + 32'd4;
      if (inst_sram_data_ok) outst = 1'b0;
      if (inst_sram_req && inst_sram_addr_ok) begin
        outst     = 1'b1;
        pend_addr = inst_sram_addr;
        delay     = $urandom_range(0, 3);
      end else if (outst && delay > 0) begin
        delay--;
      end
    end
    n_cmp++; if (delivered < 100) begin n_fail++; $display("FAIL rnd_progress got=%0d exp>=100", delivered); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_req_accept();
    test_redirect_hold();
    test_mid_reset();
`ifdef IF_ADDR_EXC_EN
    test_adel();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
